irq_sched: RTL and testbench

- Interrupt scheduler between peripheral request lines (timer, PS/2 keyboard, …) and the core88 interrupt input.
- Captures rising edges into a pending register and applies a mask. Picks the highest-priority eligible line and presents its vector on irq.
- Signals the CPU with the intr/intr_latch toggle handshake, tracks in-service state until software EOI.
- Configured through the port bus by portctl: portctl decodes the chip select and muxes irq_sched's rdata into port_i.

---
 rtl/irq_sched_pkg.sv | 21 ++
 rtl/irq_sched_if.sv | 28 ++
 rtl/irq_sched_prio_enc.sv | 28 ++
 rtl/irq_sched.sv | 159 +++++++++++++++
 tb/tb_irq_sched.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_sched_pkg.sv
// irq_sched_pkg -- command codes, reset constants and FSM states for irq_sched.
// Rev 1.0
`default_nettype none

package irq_sched_pkg;

  localparam logic [7:0] CMD_EOI       = 8'h20;
  localparam logic [7:0] CMD_SEOI      = 8'h60;
  localparam logic [7:0] CMD_SEOI_MASK = 8'hF8;
  localparam logic [7:0] CMD_RD_IRR    = 8'h0A;
  localparam logic [7:0] CMD_RD_ISR    = 8'h0B;
  localparam logic [7:0] RESET_MASK    = 8'hFF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/irq_sched_if.sv
// irq_sched_if -- port-bus register access plus the CPU interrupt handshake.
// Rev 1.0
`default_nettype none

interface irq_sched_if;

  logic       sel;
  logic       a0;
  logic       wr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       intr;
  logic       intr_latch;
  logic [7:0] irq;

  modport master (
    output sel, a0, wr, wdata, intr_latch,
    input  rdata, intr, irq
  );

  modport slave (
    input  sel, a0, wr, wdata, intr_latch,
    output rdata, intr, irq
  );

endinterface

`default_nettype wire

// File: rtl/irq_sched_prio_enc.sv
// irq_prio_enc -- lowest-set-bit priority encoder (bit 0 wins) with a valid flag.
// Rev 1.0
`default_nettype none

module irq_prio_enc #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  wire [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scanning downward lets the lowest set bit overwrite the others.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_sched.sv
// irq_sched -- edge-captured, maskable, nested-priority interrupt scheduler
// driving the core88 intr/intr_latch toggle handshake. Rev 1.0
`default_nettype none

module irq_sched
  import irq_sched_pkg::*;
#(
  parameter int         NIRQ     = 8,
  parameter logic [7:0] VEC_BASE = 8'h08
) (
  input  wire            clock,
  input  wire            resetn,
  input  wire [NIRQ-1:0] irq_req,
  irq_sched_if.slave     bus
);

  localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  sched_state_t    r_state;
  sched_state_t    w_state_next;

  logic [NIRQ-1:0] r_prev;
  logic [NIRQ-1:0] r_pending;
  logic [NIRQ-1:0] r_isr;
  logic [NIRQ-1:0] r_mask;
  logic            r_rsel;
  logic            r_intr;
  logic [7:0]      r_irq;

  logic [NIRQ-1:0] w_rise;
  logic [NIRQ-1:0] w_cand;
  logic [NIRQ-1:0] w_hp_onehot;
  logic [NIRQ-1:0] w_take;
  logic [NIRQ-1:0] w_eoi_clr;
  logic [IW-1:0]   w_hp_idx;
  logic [IW-1:0]   w_hs_idx;
  logic            w_hp_valid;
  logic            w_hs_valid;
  logic            w_eligible;
  logic            w_deliver;
  logic            w_ack;
  logic            w_cmd_wr;
  logic            w_mask_wr;
  logic [7:0]      w_rdata;

  assign w_rise    = irq_req & ~r_prev;
  assign w_cand    = r_pending & ~r_mask;
  assign w_cmd_wr  = bus.sel & bus.wr & ~bus.a0;
  assign w_mask_wr = bus.sel & bus.wr & bus.a0;
  assign w_ack     = (bus.intr_latch == r_intr);

  irq_prio_enc #(.N(NIRQ), .IW(IW)) u_cand_enc (
    .vec   (w_cand),
    .idx   (w_hp_idx),
    .valid (w_hp_valid)
  );

  irq_prio_enc #(.N(NIRQ), .IW(IW)) u_isr_enc (
    .vec   (r_isr),
    .idx   (w_hs_idx),
    .valid (w_hs_valid)
  );

  // Only a strictly higher priority than everything in service may nest.
  assign w_eligible = w_hp_valid & (~w_hs_valid | (w_hp_idx < w_hs_idx));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_eligible) w_state_next = WAIT;
      WAIT:    if (w_ack)      w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_deliver = 1'b0;
    case (r_state)
      IDLE:    w_deliver = w_eligible;
      default: w_deliver = 1'b0;
    endcase
  end

  always_comb begin
    w_hp_onehot           = '0;
    w_hp_onehot[w_hp_idx] = w_hp_valid;
  end

  assign w_take = w_deliver ? w_hp_onehot : '0;

  always_comb begin
    w_eoi_clr = '0;
    if (w_cmd_wr) begin
      if (bus.wdata == CMD_EOI && w_hs_valid) begin
        w_eoi_clr[w_hs_idx] = 1'b1;
      end
      if ((bus.wdata & CMD_SEOI_MASK) == CMD_SEOI && int'(bus.wdata[2:0]) < NIRQ) begin
        w_eoi_clr[bus.wdata[2:0]] = 1'b1;
      end
    end
  end

  // A rise in the delivery cycle re-arms the line, so set beats clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_isr     <= '0;
      r_mask    <= RESET_MASK[NIRQ-1:0];
      r_rsel    <= 1'b0;
      r_intr    <= 1'b0;
      r_irq     <= 8'h00;
    end else begin
      r_prev    <= irq_req;
      r_pending <= (r_pending & ~w_take) | w_rise;
      r_isr     <= (r_isr & ~w_eoi_clr) | w_take;
      if (w_mask_wr) begin
        r_mask <= bus.wdata[NIRQ-1:0];
      end
      if (w_cmd_wr && bus.wdata == CMD_RD_IRR) begin
        r_rsel <= 1'b0;
      end else if (w_cmd_wr && bus.wdata == CMD_RD_ISR) begin
        r_rsel <= 1'b1;
      end
      if (w_deliver) begin
        r_irq  <= VEC_BASE + 8'(w_hp_idx);
        r_intr <= ~r_intr;
      end
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    if (bus.sel) begin
      if (bus.a0) begin
        w_rdata[NIRQ-1:0] = r_mask;
      end else if (r_rsel) begin
        w_rdata[NIRQ-1:0] = r_isr;
      end else begin
        w_rdata[NIRQ-1:0] = r_pending;
      end
    end
  end

  assign bus.rdata = w_rdata;
  assign bus.intr  = r_intr;
  assign bus.irq   = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_irq_sched.sv
// tb_irq_sched -- directed scenarios plus randomized traffic checked every cycle
// against a behavioural scheduler model. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_irq_sched;

  localparam int         NIRQ     = 8;
  localparam logic [7:0] VEC_BASE = 8'h08;

  logic            clock    = 1'b0;
  logic            resetn   = 1'b0;
  logic [NIRQ-1:0] irq_req  = '0;
  logic            check_en = 1'b0;
  int              n_tests  = 0;
  int              n_fail   = 0;

  irq_sched_if bus ();

  irq_sched #(.NIRQ(NIRQ), .VEC_BASE(VEC_BASE)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .irq_req (irq_req),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Behavioural model of the scheduler.
  logic [7:0] m_pending, m_isr, m_mask, m_irq, m_prev;
  logic       m_rsel, m_intr, m_busy;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < NIRQ; i++) if (v[i]) return i;
    return NIRQ;
  endfunction

  task automatic model_reset();
    m_pending = 8'h00; m_isr = 8'h00; m_mask = 8'hFF; m_irq = 8'h00;
    m_prev = 8'h00; m_rsel = 1'b0; m_intr = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] rise, cand, npend, nisr;
    int hp, hs;
    logic deliver;
    rise    = irq_req & ~m_prev;
    cand    = m_pending & ~m_mask;
    hp      = lowest(cand);
    hs      = lowest(m_isr);
    deliver = !m_busy && hp < NIRQ && hp < hs;
    npend   = m_pending | rise;
    nisr    = m_isr;
    if (bus.sel && bus.wr) begin
      if (bus.a0) m_mask = bus.wdata;
      else begin
        if (bus.wdata == 8'h20 && hs < NIRQ) nisr[hs] = 1'b0;
        if (bus.wdata[7:3] == 5'b01100 && int'(bus.wdata[2:0]) < NIRQ) nisr[bus.wdata[2:0]] = 1'b0;
        if (bus.wdata == 8'h0A) m_rsel = 1'b0;
        if (bus.wdata == 8'h0B) m_rsel = 1'b1;
      end
    end
    if (deliver) begin
      if (!rise[hp]) npend[hp] = 1'b0;
      nisr[hp] = 1'b1;
      m_irq    = VEC_BASE + 8'(hp);
      m_intr   = ~m_intr;
      m_busy   = 1'b1;
    end else if (m_busy && bus.intr_latch == m_intr) begin
      m_busy = 1'b0;
    end
    m_pending = npend;
    m_isr     = nisr;
    m_prev    = irq_req;
  endtask

  function automatic logic [7:0] exp_rdata();
    if (!bus.sel) return 8'h00;
    if (bus.a0)   return m_mask;
    return m_rsel ? m_isr : m_pending;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) model_reset();
      else         model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (check_en) begin
        check("cyc_intr",  {7'd0, bus.intr}, {7'd0, m_intr});
        check("cyc_irq",   bus.irq,   m_irq);
        check("cyc_rdata", bus.rdata, exp_rdata());
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wr_reg(input logic a0v, input logic [7:0] d);
    bus.sel = 1'b1; bus.wr = 1'b1; bus.a0 = a0v; bus.wdata = d;
    tick();
    bus.sel = 1'b0; bus.wr = 1'b0; bus.a0 = 1'b0; bus.wdata = 8'h00;
  endtask

  task automatic rd_reg(input logic a0v, output logic [7:0] d);
    bus.sel = 1'b1; bus.wr = 1'b0; bus.a0 = a0v;
    #1;
    d = bus.rdata;
    bus.sel = 1'b0; bus.a0 = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    irq_req = v;
    tick();
    irq_req = '0;
  endtask

  task automatic ack();
    bus.intr_latch = m_intr;
    tick();
  endtask

  initial begin
    logic [7:0] rd;
    bus.sel = 1'b0; bus.wr = 1'b0; bus.a0 = 1'b0; bus.wdata = 8'h00; bus.intr_latch = 1'b0;
    repeat (3) @(posedge clock);
    tick();
    resetn   = 1'b1;
    check_en = 1'b1;

    rd_reg(1'b1, rd); check("rst_mask", rd, 8'hFF);
    rd_reg(1'b0, rd); check("rst_irr", rd, 8'h00);
    check("rst_sel0", bus.rdata, 8'h00);
    check("rst_intr", {7'd0, bus.intr}, 8'h00);
    check("rst_irq", bus.irq, 8'h00);

    // Unmask line 1 and deliver it
    wr_reg(1'b1, 8'hFD);
    pulse(8'h02);
    rd_reg(1'b0, rd); check("s1_pend", rd, 8'h02);
    check("s1_intr_pre", {7'd0, bus.intr}, 8'h00);
    tick();
    check("s1_intr", {7'd0, bus.intr}, 8'h01);
    check("s1_irq", bus.irq, 8'h09);
    wr_reg(1'b0, 8'h0B);
    rd_reg(1'b0, rd); check("s1_isr", rd, 8'h02);
    ack();
    wr_reg(1'b0, 8'h20);
    rd_reg(1'b0, rd); check("s1_eoi", rd, 8'h00);

    // Masked line, then a mask write releases it
    wr_reg(1'b1, 8'hFF);
    wr_reg(1'b0, 8'h0A);
    pulse(8'h01);
    rd_reg(1'b0, rd); check("s2_pend", rd, 8'h01);
    tick(); tick();
    check("s2_hold", {7'd0, bus.intr}, 8'h01);
    wr_reg(1'b1, 8'h00);
    check("s2_oldmask", {7'd0, bus.intr}, 8'h01);
    tick();
    check("s2_intr", {7'd0, bus.intr}, 8'h00);
    check("s2_irq", bus.irq, 8'h08);
    ack();
    wr_reg(1'b0, 8'h20);

    // Two simultaneous rises, EOI-gated second delivery, then nesting
    pulse(8'h0A);
    tick();
    check("s3_irq1", bus.irq, 8'h09);
    check("s3_intr1", {7'd0, bus.intr}, 8'h01);
    ack();
    tick(); tick();
    check("s3_no3", bus.irq, 8'h09);
    rd_reg(1'b0, rd); check("s3_pend3", rd, 8'h08);
    wr_reg(1'b0, 8'h20);
    tick();
    check("s3_irq3", bus.irq, 8'h0B);
    check("s3_intr3", {7'd0, bus.intr}, 8'h00);
    ack();
    pulse(8'h01);
    tick();
    check("s3_nest_irq", bus.irq, 8'h08);
    check("s3_nest_intr", {7'd0, bus.intr}, 8'h01);
    wr_reg(1'b0, 8'h0B);
    rd_reg(1'b0, rd); check("s3_isr_nest", rd, 8'h09);

    // Outstanding request is held while other lines rise
    pulse(8'h24);
    tick(); tick();
    check("s4_hold_irq", bus.irq, 8'h08);
    check("s4_hold_intr", {7'd0, bus.intr}, 8'h01);
    wr_reg(1'b0, 8'h60);
    wr_reg(1'b0, 8'h63);
    rd_reg(1'b0, rd); check("s4_seoi", rd, 8'h00);
    ack();
    tick();
    check("s4_second_intr", {7'd0, bus.intr}, 8'h00);
    check("s4_second_irq", bus.irq, 8'h0A);

    // Asynchronous reset while a request is outstanding
    bus.sel = 1'b1; bus.a0 = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("s5_intr", {7'd0, bus.intr}, 8'h00);
    check("s5_irq", bus.irq, 8'h00);
    check("s5_mask", bus.rdata, 8'hFF);
    bus.a0 = 1'b0;
    #1;
    check("s5_pend", bus.rdata, 8'h00);
    bus.sel = 1'b0;
    bus.intr_latch = 1'b0;
    tick();
    resetn = 1'b1;
    wr_reg(1'b0, 8'h0B);
    rd_reg(1'b0, rd); check("s5_isr", rd, 8'h00);

    // Randomized traffic; the per-cycle compare does the checking
    for (int c = 0; c < 3000; c++) begin
      irq_req   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      bus.sel   = ($urandom_range(0, 3) != 0);
      bus.a0    = 1'($urandom_range(0, 1));
      bus.wr    = 1'b0;
      bus.wdata = 8'($urandom);
      if (bus.sel && $urandom_range(0, 4) == 0) begin
        bus.wr = 1'b1;
        bus.a0 = 1'b0;
        case ($urandom_range(0, 5))
          0: begin bus.a0 = 1'b1; bus.wdata = 8'($urandom) & 8'($urandom); end
          1: bus.wdata = 8'h20;
          2: bus.wdata = 8'h60 | 8'($urandom_range(0, 7));
          3: bus.wdata = 8'h0A;
          4: bus.wdata = 8'h0B;
          default: bus.wdata = 8'($urandom);
        endcase
      end
      if (bus.intr_latch != m_intr && $urandom_range(0, 2) == 0) bus.intr_latch = m_intr;
      tick();
    end

    bus.sel = 1'b0; bus.wr = 1'b0; irq_req = '0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
